// File: rtl/sll_seq_if.sv
// Start/busy/done handshake and operand/result bus for the sequential shift-left unit.
// The ALU sequencer uses the master modport; sll_seq uses the slave modport.
interface sll_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] movement;
    logic [31:0] out;
    logic        busy;
    logic        done;

    modport master (output start, a, movement, input out, busy, done);
    modport slave  (input start, a, movement, output out, busy, done);
endinterface

// File: rtl/sll_seq.sv
// Sequential 32-bit logical shift-left: one binary-weighted stage (1,2,4,8,16) per clock.
// Optional macro SLL_SEQ_EARLY_DONE_EN finishes as soon as no higher amount bits remain.
//
// state | meaning
// IDLE  | waiting for start; out holds the last result
// SHIFT | applying stage `stage` (0..4) to the working register
module sll_seq (
    input  logic       clk,
    input  logic       rst_n,
    sll_seq_if.slave   bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state;
    logic [31:0] work;
    logic [4:0]  amt;
    logic [2:0]  stage;
    logic [31:0] out_q;
    logic        busy_q;
    logic        done_q;

    logic        step_en;
    logic [4:0]  step_amt;
    logic        last;
    logic [31:0] work_nxt;

    always_comb begin
        step_en  = 1'b0;
        step_amt = 5'd0;
        last     = 1'b1;
        case (stage)
            3'd0: begin step_en = amt[0]; step_amt = 5'd1;  end
            3'd1: begin step_en = amt[1]; step_amt = 5'd2;  end
            3'd2: begin step_en = amt[2]; step_amt = 5'd4;  end
            3'd3: begin step_en = amt[3]; step_amt = 5'd8;  end
            3'd4: begin step_en = amt[4]; step_amt = 5'd16; end
            default: ;
        endcase
`ifdef SLL_SEQ_EARLY_DONE_EN
        // Remaining stages are no-ops once every higher amount bit is clear.
        case (stage)
            3'd0:    last = (amt[4:1] == 4'd0);
            3'd1:    last = (amt[4:2] == 3'd0);
            3'd2:    last = (amt[4:3] == 2'd0);
            3'd3:    last = ~amt[4];
            default: last = 1'b1;
        endcase
`else
        last = (stage >= 3'd4);
`endif
        work_nxt = step_en ? (work << step_amt) : work;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            work   <= 32'd0;
            amt    <= 5'd0;
            stage  <= 3'd0;
            out_q  <= 32'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        work   <= bus.a;
                        amt    <= bus.movement[4:0];
                        stage  <= 3'd0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    work  <= work_nxt;
                    stage <= stage + 3'd1;
                    if (last) begin
                        out_q  <= work_nxt;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_sll_seq.sv
// Randomized self-checking bench for sll_seq against a plain-arithmetic shift/latency model.
module tb_sll_seq;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [31:0] model_out;

    sll_seq_if bus ();

    sll_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_latency(input logic [4:0] m);
        int hb;
        hb = 0;
        for (int i = 0; i < 5; i++) if (m[i]) hb = i;
`ifdef SLL_SEQ_EARLY_DONE_EN
        return hb + 1;
`else
        return 5;
`endif
    endfunction

    // Launches one operation and returns in the cycle done is observed.
    task automatic run_op(input logic [31:0] av, input logic [31:0] mv, input int ignore_at);
        logic [31:0] exp_out;
        int          exp_lat;
        int          lat;
        exp_out = av << mv[4:0];
        exp_lat = exp_latency(mv[4:0]);
        bus.start    = 1'b1;
        bus.a        = av;
        bus.movement = mv;
        tick();
        bus.start    = 1'b0;
        bus.a        = $urandom;
        bus.movement = $urandom;
        lat = 0;
        while (!bus.done && lat < 8) begin
            check("busy_inflight", bus.busy, 1'b1);
            check("out_held", bus.out, model_out);
            bus.start = (lat == ignore_at);
            tick();
            bus.start = 1'b0;
            lat++;
        end
        check("done_seen", bus.done, 1'b1);
        check("latency", lat, exp_lat);
        check("result", bus.out, exp_out);
        check("busy_at_done", bus.busy, 1'b0);
        model_out = exp_out;
    endtask

    task automatic idle_cycle();
        tick();
        check("done_one_pulse", bus.done, 1'b0);
        check("busy_idle", bus.busy, 1'b0);
        check("out_idle_hold", bus.out, model_out);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        model_out    = 32'd0;
        bus.start    = 1'b0;
        bus.a        = 32'd0;
        bus.movement = 32'd0;
        rst_n        = 1'b0;
        #23;
        check("rst_out", bus.out, 32'd0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        rst_n = 1'b1;
        tick();
        idle_cycle();

        run_op(32'h0000_0001, 32'd31, -1);
        idle_cycle();
        run_op(32'h0000_00FF, 32'h0000_0025, -1);
        idle_cycle();
        run_op(32'hFFFF_FFFF, 32'd4, -1);
        idle_cycle();
        run_op(32'hA5C3_0F96, 32'd0, -1);
        idle_cycle();

        // Second start arrives while busy and must be ignored; then a back-to-back start.
        run_op(32'h1234_5678, 32'd8, 2);
        run_op(32'h0000_0001, 32'd1, -1);
        idle_cycle();

        // Reset mid-operation discards the operation.
        bus.start    = 1'b1;
        bus.a        = 32'hDEAD_BEEF;
        bus.movement = 32'd3;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out", bus.out, 32'd0);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_done", bus.done, 1'b0);
        model_out = 32'd0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            check("no_done_after_rst", bus.done, 1'b0);
            check("no_busy_after_rst", bus.busy, 1'b0);
            check("out_after_rst", bus.out, 32'd0);
        end
        run_op(32'h0000_0003, 32'd2, -1);
        idle_cycle();

        for (int i = 0; i < 60; i++) begin
            run_op($urandom, $urandom, ($urandom_range(0, 3) == 0) ? 1 : -1);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
